// File: rtl/layer_stream_serializer.sv
// layer_stream_serializer: captures a layer's parallel output vector and
// streams it one element per beat over valid/ready, with one pending slot
// so a vector that arrives mid-stream is held rather than lost.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | active slot empty, nothing to send
// SEND  | active slot occupied, presenting element at beat counter
module layer_stream_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int REVERSE     = 0,
    parameter int IW          = $clog2(NUM_NEURONS)
) (
    input  logic                              s_axi_aclk,
    input  logic                              s_axi_aresetn,
    input  logic                              soft_reset,
    input  logic                              in_valid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
    output logic                              in_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic [IW-1:0]                     out_index,
    output logic                              busy,
    output logic                              overflow
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam logic [IW-1:0] LAST_CNT = IW'(NUM_NEURONS - 1);

    state_t                            state_q, state_d;
    logic [IW-1:0]                     cnt_q, cnt_d;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] active_q, active_d;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] pending_q, pending_d;
    logic                              pend_valid_q, pend_valid_d;
    logic                              overflow_q, overflow_d;

    logic                              beat;
    logic                              last_beat;
    logic                              capture;
    logic [IW-1:0]                     sel;
    logic [DATA_WIDTH-1:0]             elem [NUM_NEURONS];

    // Handshake decodes; in_ready depends only on the pending register.
    assign in_ready  = ~pend_valid_q;
    assign out_valid = (state_q == SEND);
    assign beat      = out_valid && out_ready;
    assign last_beat = beat && (cnt_q == LAST_CNT);
    assign capture   = in_valid && in_ready;

    assign out_last  = (state_q == SEND) && (cnt_q == LAST_CNT);
    assign out_index = cnt_q;
    assign busy      = (state_q == SEND) || pend_valid_q;
    assign overflow  = overflow_q;

    // Slice the active vector into elements and pick the one in send order.
    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            elem[i] = active_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
        sel      = (REVERSE != 0) ? (LAST_CNT - cnt_q) : cnt_q;
        out_data = (state_q == SEND) ? elem[sel] : '0;
    end

    // State register and slot storage; soft_reset acts like reset.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (soft_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state: capture, beat counting, pending hand-off and overflow.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        overflow_d   = overflow_q | (in_valid && !in_ready);

        case (state_q)
            IDLE: begin
                if (capture) begin
                    active_d = in_data;
                    cnt_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (last_beat) begin
                    cnt_d = '0;
                    if (pend_valid_q) begin
                        // Zero-bubble hand-off; capture is impossible here.
                        active_d     = pending_q;
                        pend_valid_d = 1'b0;
                    end else if (capture) begin
                        active_d = in_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (beat) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (capture) begin
                        pending_d    = in_data;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_layer_stream_serializer.sv
// Directed bench for layer_stream_serializer (4 x 8-bit, both orders).
module tb_layer_stream_serializer;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            soft_reset = 1'b0;
    logic            in_valid = 1'b0;
    logic [N*DW-1:0] in_data = '0;
    logic            out_ready = 1'b1;

    logic            in_ready, out_valid, out_last, busy, overflow;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_index;

    logic            r_in_ready, r_out_valid, r_out_last, r_busy, r_overflow;
    logic [DW-1:0]   r_out_data;
    logic [IW-1:0]   r_out_index;

    int n_assert = 0;
    int n_fail   = 0;
    int accepted;

    always #5 clk = ~clk;

    layer_stream_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .REVERSE(0)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .soft_reset(soft_reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_index(out_index), .busy(busy), .overflow(overflow)
    );

    layer_stream_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .REVERSE(1)) dut_rev (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .soft_reset(soft_reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(r_in_ready),
        .out_data(r_out_data), .out_valid(r_out_valid), .out_ready(out_ready),
        .out_last(r_out_last), .out_index(r_out_index), .busy(r_busy), .overflow(r_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check a forward-order beat: valid, data, index, last.
    task automatic beat_chk(input string tag, input logic [7:0] d, input int idx, input logic lst);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_index"}, 32'(out_index), 32'(idx));
        chk({tag, "_last"},  32'(out_last),  32'(lst));
    endtask

    logic [7:0] exp_pre [7] = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04};
    logic       rdy_tab [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] stall_d;

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        rst_n = 1'b1;
        tick();

        // Single vector, forward and reverse order
        in_valid = 1'b1; in_data = 32'h44332211; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        beat_chk("t1_b0", 8'h11, 0, 1'b0);
        chk("t1r_b0", 32'(r_out_data), 32'h44);
        tick();
        beat_chk("t1_b1", 8'h22, 1, 1'b0);
        chk("t1r_b1", 32'(r_out_data), 32'h33);
        tick();
        beat_chk("t1_b2", 8'h33, 2, 1'b0);
        chk("t1r_b2", 32'(r_out_data), 32'h22);
        tick();
        beat_chk("t1_b3", 8'h44, 3, 1'b1);
        chk("t1r_b3", 32'(r_out_data), 32'h11);
        chk("t1r_last", 32'(r_out_last), 32'd1);
        tick();
        chk("t1_end_valid", 32'(out_valid), 32'd0);
        chk("t1_end_busy",  32'(busy),      32'd0);

        // Pending slot: A then B two cycles later, contiguous beats
        in_valid = 1'b1; in_data = 32'h04030201;
        tick();
        in_valid = 1'b0;
        beat_chk("t3_a0", 8'h01, 0, 1'b0);
        tick();
        beat_chk("t3_a1", 8'h02, 1, 1'b0);
        in_valid = 1'b1; in_data = 32'h08070605;
        tick();
        in_valid = 1'b0;
        beat_chk("t3_a2", 8'h03, 2, 1'b0);
        chk("t3_in_ready_lo0", 32'(in_ready), 32'd0);
        tick();
        beat_chk("t3_a3", 8'h04, 3, 1'b1);
        chk("t3_in_ready_lo1", 32'(in_ready), 32'd0);
        tick();
        beat_chk("t3_b0", 8'h05, 0, 1'b0);
        chk("t3_in_ready_hi", 32'(in_ready), 32'd1);
        tick();
        beat_chk("t3_b1", 8'h06, 1, 1'b0);
        tick();
        beat_chk("t3_b2", 8'h07, 2, 1'b0);
        tick();
        beat_chk("t3_b3", 8'h08, 3, 1'b1);
        tick();
        chk("t3_end_valid", 32'(out_valid), 32'd0);

        // Overflow: A, B, C on consecutive cycles; C is dropped
        in_valid = 1'b1; in_data = 32'h04030201;
        tick();
        in_data = 32'h08070605;
        tick();
        in_data = 32'h0c0b0a09;
        chk("t4_in_ready_b", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("t4_overflow_set", 32'(overflow), 32'd1);
        beat_chk("t4_a2", 8'h03, 2, 1'b0);
        tick();
        beat_chk("t4_a3", 8'h04, 3, 1'b1);
        tick();
        beat_chk("t4_b0", 8'h05, 0, 1'b0);
        tick();
        tick();
        tick();
        beat_chk("t4_b3", 8'h08, 3, 1'b1);
        tick();
        chk("t4_end_valid",   32'(out_valid), 32'd0);
        chk("t4_overflow_st", 32'(overflow),  32'd1);
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        chk("t4_soft_ovf",   32'(overflow), 32'd0);
        chk("t4_soft_ready", 32'(in_ready), 32'd1);
        chk("t4_soft_busy",  32'(busy),     32'd0);

        // Backpressure: stall pattern, each element exactly once
        in_valid = 1'b1; in_data = 32'h04030201; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        accepted = 0;
        for (int i = 0; i < 7; i++) begin
            out_ready = rdy_tab[i];
            stall_d = exp_pre[i];
            chk($sformatf("t5_data%0d", i), 32'(out_data), 32'(stall_d));
            chk($sformatf("t5_valid%0d", i), 32'(out_valid), 32'd1);
            if (out_valid && out_ready) accepted++;
            tick();
        end
        out_ready = 1'b1;
        chk("t5_end_valid", 32'(out_valid), 32'd0);
        chk("t5_accepted",  32'(accepted),  32'd4);

        // Asynchronous reset mid-stream, then a fresh vector
        in_valid = 1'b1; in_data = 32'h44332211;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        beat_chk("t6_pre", 8'h33, 2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_busy",  32'(busy),      32'd0);
        chk("t6_async_index", 32'(out_index), 32'd0);
        tick();
        chk("t6_held_valid", 32'(out_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'hddccbbaa;
        tick();
        in_valid = 1'b0;
        beat_chk("t6_n0", 8'haa, 0, 1'b0);
        tick();
        beat_chk("t6_n1", 8'hbb, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
